// File: rtl/mips_pkg.sv
// Shared definitions for the ID/EX issue stage: ALU opcodes, default widths,
// the EX control record and an opcode classification helper.
package mips_pkg;

   localparam int DW_DEF = 32;
   localparam int RW_DEF = 5;
   localparam int unsigned REG_ZERO = 0;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_LUI  = 3'b011;
   localparam logic [2:0] ALU_RSV0 = 3'b100;
   localparam logic [2:0] ALU_RSV1 = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   typedef struct packed {
      logic       valid;
      logic [2:0] alu_op;
      logic       use_imm;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       illegal;
   } ex_ctrl_t;

   function automatic logic is_reserved(input logic [2:0] op);
      return (op == ALU_RSV0) || (op == ALU_RSV1);
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass selector: EX/MEM result beats MEM/WB result beats the
// register-file value; register $0 always reads its file value.
module fwd_mux
   import mips_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic [RW-1:0] addr,
   input  logic [DW-1:0] rf_val,
   input  logic          exm_reg_write,
   input  logic [RW-1:0] exm_rd,
   input  logic [DW-1:0] exm_result,
   input  logic          mw_reg_write,
   input  logic [RW-1:0] mw_rd,
   input  logic [DW-1:0] mw_result,
   output logic [DW-1:0] val
);

   always_comb begin
      val = rf_val;
      if (addr != RW'(REG_ZERO)) begin
         if (exm_reg_write && (exm_rd == addr))
            val = exm_result;
         else if (mw_reg_write && (mw_rd == addr))
            val = mw_result;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and combinational
// operand forwarding applied to the captured instruction while it sits in EX.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [2:0]    id_alu_op,
   input  logic [RW-1:0] id_rs_addr,
   input  logic [RW-1:0] id_rt_addr,
   input  logic [RW-1:0] id_rd_addr,
   input  logic [DW-1:0] id_rs_val,
   input  logic [DW-1:0] id_rt_val,
   input  logic [DW-1:0] id_imm,
   input  logic          id_use_imm,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          flush,
   input  logic          mem_stall,
   input  logic          exm_reg_write,
   input  logic [RW-1:0] exm_rd,
   input  logic [DW-1:0] exm_result,
   input  logic          mw_reg_write,
   input  logic [RW-1:0] mw_rd,
   input  logic [DW-1:0] mw_result,
   output logic          id_stall,
   output logic          ex_valid,
   output logic [2:0]    ex_alu_op,
   output logic [DW-1:0] ex_op_a,
   output logic [DW-1:0] ex_op_b,
   output logic [DW-1:0] ex_store_data,
   output logic [RW-1:0] ex_rd,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          ex_illegal
);

   ex_ctrl_t      ctrl_reg;
   ex_ctrl_t      ctrl_next;
   logic [RW-1:0] rs_addr_reg;
   logic [RW-1:0] rt_addr_reg;
   logic [RW-1:0] rd_reg;
   logic [DW-1:0] rs_val_reg;
   logic [DW-1:0] rt_val_reg;
   logic [DW-1:0] imm_reg;
   logic          illegal_next;
   logic          load_use;

   logic [RW-1:0] src_addr [2];
   logic [DW-1:0] src_val  [2];
   logic [DW-1:0] fwd_val  [2];

   // Reserved opcodes still enter EX, but must never write or touch memory.
   always_comb begin
      illegal_next        = id_valid & is_reserved(id_alu_op);
      ctrl_next           = '0;
      ctrl_next.valid     = id_valid;
      ctrl_next.alu_op    = id_alu_op;
      ctrl_next.use_imm   = id_use_imm;
      ctrl_next.reg_write = id_valid & id_reg_write & ~illegal_next;
      ctrl_next.mem_read  = id_valid & id_mem_read & ~illegal_next;
      ctrl_next.mem_write = id_valid & id_mem_write & ~illegal_next;
      ctrl_next.illegal   = illegal_next;
   end

   assign load_use = ctrl_reg.valid & ctrl_reg.mem_read & id_valid &
                     (rd_reg != RW'(REG_ZERO)) &
                     ((rd_reg == id_rs_addr) | ((rd_reg == id_rt_addr) & ~id_use_imm));

   assign id_stall = load_use | mem_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_reg    <= '0;
         rs_addr_reg <= '0;
         rt_addr_reg <= '0;
         rd_reg      <= '0;
         rs_val_reg  <= '0;
         rt_val_reg  <= '0;
         imm_reg     <= '0;
      end else if (mem_stall) begin
         ctrl_reg <= ctrl_reg;
      end else if (flush || load_use) begin
         ctrl_reg    <= '0;
         rs_addr_reg <= '0;
         rt_addr_reg <= '0;
         rd_reg      <= '0;
         rs_val_reg  <= '0;
         rt_val_reg  <= '0;
         imm_reg     <= '0;
      end else begin
         ctrl_reg    <= ctrl_next;
         rs_addr_reg <= id_rs_addr;
         rt_addr_reg <= id_rt_addr;
         rd_reg      <= id_rd_addr;
         rs_val_reg  <= id_rs_val;
         rt_val_reg  <= id_rt_val;
         imm_reg     <= id_imm;
      end
   end

   assign src_addr[0] = rs_addr_reg;
   assign src_addr[1] = rt_addr_reg;
   assign src_val[0]  = rs_val_reg;
   assign src_val[1]  = rt_val_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         fwd_mux #(.DW(DW), .RW(RW)) u_fwd (
            .addr          (src_addr[gi]),
            .rf_val        (src_val[gi]),
            .exm_reg_write (exm_reg_write),
            .exm_rd        (exm_rd),
            .exm_result    (exm_result),
            .mw_reg_write  (mw_reg_write),
            .mw_rd         (mw_rd),
            .mw_result     (mw_result),
            .val           (fwd_val[gi])
         );
      end
   endgenerate

   assign ex_valid      = ctrl_reg.valid;
   assign ex_alu_op     = ctrl_reg.alu_op;
   assign ex_rd         = rd_reg;
   assign ex_reg_write  = ctrl_reg.reg_write;
   assign ex_mem_read   = ctrl_reg.mem_read;
   assign ex_mem_write  = ctrl_reg.mem_write;
   assign ex_illegal    = ctrl_reg.illegal;
   assign ex_op_a       = fwd_val[0];
   assign ex_store_data = fwd_val[1];
   assign ex_op_b       = ctrl_reg.use_imm ? imm_reg : fwd_val[1];

endmodule
